// File: rtl/tb_uart_monitor.sv
// UART receive monitor for the simulation top level: decodes frames from the
// DUT's txd, buffers bytes in a show-ahead FIFO, and keeps a cycle counter
// plus an idle-line watchdog.
module tb_uart_monitor #(
  parameter int unsigned CLK_DIV        = 16,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned PARITY_EN      = 0,
  parameter int unsigned PARITY_ODD     = 0,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rxd,
  input  logic                          clr,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [7:0]                    rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow,
  output logic                          idle_timeout,
  output logic [63:0]                   cycles
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned DW   = $clog2(CLK_DIV);
  localparam int unsigned BW   = 3;
  localparam int unsigned IW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned HALF = CLK_DIV / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t state;
  state_t state_next;

  logic                 rx_meta;
  logic                 rx_s;
  logic [DW-1:0]        div;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_ok;
  logic [IW-1:0]        idle_cnt;
  logic [IW-1:0]        idle_next;

  logic                 tick_c;
  logic                 last_bit_c;
  logic                 div_clr_c;
  logic                 start_c;
  logic                 confirm_c;
  logic                 shift_c;
  logic                 par_sample_c;
  logic                 push_c;
  logic                 set_perr_c;
  logic                 set_ferr_c;
  logic [7:0]           push_byte_c;

  logic [7:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 full_c;
  logic                 pop_c;
  logic                 accept_c;
  logic                 drop_c;
  logic [CW-1:0]        count_next;
  logic [7:0]           head_next;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
    end
  end

  // Sample strobe: half a bit into the start bit, then one full bit period apart
  always_comb begin
    tick_c     = (state == S_START) ? (div == DW'(HALF - 1)) : (div == DW'(CLK_DIV - 1));
    last_bit_c = (bit_cnt == BW'(DATA_BITS - 1));
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (!rx_s) state_next = S_START;
      S_START:     if (tick_c) state_next = rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (tick_c && last_bit_c) state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY:    if (tick_c) state_next = S_STOP;
      S_STOP:      if (tick_c) state_next = rx_s ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_s) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // FSM outputs: per-state sample strobes; a low stop bit outranks a parity error
  always_comb begin
    div_clr_c    = 1'b0;
    start_c      = 1'b0;
    confirm_c    = 1'b0;
    shift_c      = 1'b0;
    par_sample_c = 1'b0;
    push_c       = 1'b0;
    set_perr_c   = 1'b0;
    set_ferr_c   = 1'b0;
    case (state)
      S_IDLE: begin
        div_clr_c = 1'b1;
        start_c   = !rx_s;
      end
      S_START: begin
        div_clr_c = tick_c;
        confirm_c = tick_c && !rx_s;
      end
      S_DATA: begin
        div_clr_c = tick_c;
        shift_c   = tick_c;
      end
      S_PARITY: begin
        div_clr_c    = tick_c;
        par_sample_c = tick_c;
      end
      S_STOP: begin
        div_clr_c  = tick_c;
        push_c     = tick_c && rx_s && par_ok;
        set_perr_c = tick_c && rx_s && !par_ok;
        set_ferr_c = tick_c && !rx_s;
      end
      default: div_clr_c = tick_c;
    endcase
  end

  // Bit-period divider, bit counter, LSB-first shifter and parity result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_ok  <= 1'b1;
    end else begin
      div <= div_clr_c ? '0 : div + DW'(1);
      if (confirm_c) begin
        bit_cnt <= '0;
        par_ok  <= 1'b1;
      end
      if (shift_c) begin
        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (par_sample_c) par_ok <= (rx_s == ((^shreg) ^ 1'(PARITY_ODD)));
    end
  end

  // FIFO control: a push into a full FIFO survives only if a pop frees a slot
  always_comb begin
    push_byte_c = 8'(shreg);
    full_c      = (fifo_count == CW'(FIFO_DEPTH));
    pop_c       = rd_ready && (fifo_count != '0);
    accept_c    = push_c && (!full_c || pop_c);
    drop_c      = push_c && !accept_c;
    count_next  = fifo_count;
    if (accept_c && !pop_c)      count_next = fifo_count + CW'(1);
    else if (!accept_c && pop_c) count_next = fifo_count - CW'(1);
    head_next = rd_data;
    if (pop_c) begin
      if (fifo_count != CW'(1))  head_next = mem[rd_ptr + AW'(1)];
      else if (accept_c)         head_next = push_byte_c;
    end else if (fifo_count == '0 && accept_c) begin
      head_next = push_byte_c;
    end
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (accept_c) mem[wr_ptr] <= push_byte_c;
  end

  // FIFO pointers, occupancy and registered show-ahead head
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      if (accept_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)    rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_next;
      rd_valid   <= (count_next != '0);
      rd_data    <= head_next;
    end
  end

  // Sticky error flags; a new error in the same cycle as clr wins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_err  <= set_ferr_c | (frame_err & ~clr);
      parity_err <= set_perr_c | (parity_err & ~clr);
      overflow   <= drop_c | (overflow & ~clr);
    end
  end

  // Idle watchdog next value: restarts on clr or a detected start edge, saturates
  always_comb begin
    idle_next = idle_cnt;
    if (clr || start_c)                        idle_next = '0;
    else if (idle_cnt != IW'(TIMEOUT_CYCLES))  idle_next = idle_cnt + IW'(1);
  end

  // Idle watchdog, timeout flag and free-running cycle counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt     <= '0;
      idle_timeout <= 1'b0;
      cycles       <= '0;
    end else begin
      idle_cnt     <= idle_next;
      idle_timeout <= (idle_next == IW'(TIMEOUT_CYCLES));
      cycles       <= cycles + 64'd1;
    end
  end

endmodule

// File: tb/tb_tb_uart_monitor.sv
// Bench for tb_uart_monitor: one 8N1 instance with a short watchdog and one
// 8O1 instance, driven bit by bit and checked through an expected-byte queue.
module tb_tb_uart_monitor;

  localparam int unsigned CLK_DIV = 16;

  logic clk;
  logic reset;
  logic rxd_a, clr_a, ready_a, valid_a, ferr_a, perr_a, ovf_a, idle_a;
  logic rxd_b, clr_b, ready_b, valid_b, ferr_b, perr_b, ovf_b, idle_b;
  logic [7:0]  data_a, data_b;
  logic [4:0]  count_a, count_b;
  logic [63:0] cycles_a, cycles_b;

  int n_checks;
  int n_errors;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  tb_uart_monitor #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
    .FIFO_DEPTH(16), .TIMEOUT_CYCLES(50)
  ) u_a (
    .clock(clk), .reset(reset), .rxd(rxd_a), .clr(clr_a),
    .rd_valid(valid_a), .rd_ready(ready_a), .rd_data(data_a), .fifo_count(count_a),
    .frame_err(ferr_a), .parity_err(perr_a), .overflow(ovf_a),
    .idle_timeout(idle_a), .cycles(cycles_a)
  );

  tb_uart_monitor #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
    .FIFO_DEPTH(16), .TIMEOUT_CYCLES(1000000)
  ) u_b (
    .clock(clk), .reset(reset), .rxd(rxd_b), .clr(clr_b),
    .rd_valid(valid_b), .rd_ready(ready_b), .rd_data(data_b), .fifo_count(count_b),
    .frame_err(ferr_b), .parity_err(perr_b), .overflow(ovf_b),
    .idle_timeout(idle_b), .cycles(cycles_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every pop the DUT performs must match the oldest expected byte
  always @(negedge clk) begin : mon_a
    logic [63:0] exp_v;
    if (!reset && valid_a && ready_a) begin
      if (q_a.size() != 0) exp_v = 64'(q_a.pop_front());
      else                 exp_v = 64'hDEAD;
      check("a_pop_data", 64'(data_a), exp_v);
    end
  end

  always @(negedge clk) begin : mon_b
    logic [63:0] exp_v;
    if (!reset && valid_b && ready_b) begin
      if (q_b.size() != 0) exp_v = 64'(q_b.pop_front());
      else                 exp_v = 64'hDEAD;
      check("b_pop_data", 64'(data_b), exp_v);
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  task automatic set_rxd(input int which, input logic v);
    if (which == 0) rxd_a = v;
    else            rxd_b = v;
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int which, input logic v);
    set_rxd(which, v);
    wait_cycles(CLK_DIV);
  endtask

  task automatic drain(input int which, input int n);
    if (which == 0) ready_a = 1'b1;
    else            ready_b = 1'b1;
    wait_cycles(n);
    ready_a = 1'b0;
    ready_b = 1'b0;
  endtask

  // Instance b uses odd parity; the stop sample lands 11 edges into the stop bit
  task automatic send_frame(input int which, input logic [7:0] data, input logic bad_par,
                            input logic stop_val, input logic expect_push,
                            input logic probe, input logic pulse);
    logic par;
    par = ~(^data) ^ bad_par;
    if (expect_push) begin
      if (which == 0) q_a.push_back(data);
      else            q_b.push_back(data);
    end
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, data[i]);
    if (which != 0) drive_bit(which, par);
    set_rxd(which, stop_val);
    repeat (10) @(posedge clk);
    #1;
    if (pulse) ready_a = 1'b1;
    if (probe) begin
      @(negedge clk);
      check("a_valid_before_push", 64'(valid_a), 64'(0));
    end
    @(posedge clk);
    #1;
    if (pulse) ready_a = 1'b0;
    if (probe) begin
      @(negedge clk);
      check("a_valid_after_push", 64'(valid_a), 64'(1));
      check("a_data_after_push", 64'(data_a), 64'(data));
      check("a_count_after_push", 64'(count_a), 64'(1));
      check("a_flags_after_push", 64'({ferr_a, perr_a, ovf_a}), 64'(0));
    end
    wait_cycles(5);
  endtask

  task automatic pulse_clr(input int which);
    if (which == 0) clr_a = 1'b1;
    else            clr_b = 1'b1;
    wait_cycles(1);
    clr_a = 1'b0;
    clr_b = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    rxd_a = 1'b1; rxd_b = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0;
    ready_a = 1'b0; ready_b = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_rst_valid", 64'(valid_a), 64'(0));
    check("a_rst_count", 64'(count_a), 64'(0));
    check("a_rst_data", 64'(data_a), 64'(0));
    check("a_rst_flags", 64'({ferr_a, perr_a, ovf_a}), 64'(0));
    check("a_rst_idle", 64'(idle_a), 64'(0));
    check("a_rst_cycles", cycles_a, 64'(0));
    check("b_rst_valid_count", 64'({valid_b, count_b}), 64'(0));
    check("b_rst_flags", 64'({ferr_b, perr_b, ovf_b, idle_b}), 64'(0));
    reset = 1'b0;

    // Watchdog and cycle counter on an idle line
    repeat (49) @(posedge clk);
    @(negedge clk);
    check("a_idle_at_49", 64'(idle_a), 64'(0));
    check("a_cycles_49", cycles_a, 64'(49));
    @(posedge clk);
    @(negedge clk);
    check("a_idle_at_50", 64'(idle_a), 64'(1));
    check("a_cycles_50", cycles_a, 64'(50));
    wait_cycles(10);

    // 0x55 in 8N1; the start edge drops the watchdog
    fork
      send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      begin
        repeat (3) @(negedge clk);
        check("a_idle_held", 64'(idle_a), 64'(1));
        @(negedge clk);
        check("a_idle_dropped", 64'(idle_a), 64'(0));
        check("a_cycles_63", cycles_a, 64'(63));
      end
    join
    drain(0, 2);
    @(negedge clk);
    check("a_valid_after_pop", 64'(valid_a), 64'(0));
    check("a_count_after_pop", 64'(count_a), 64'(0));
    wait_cycles(1);

    // False start, then 0xA3
    rxd_a = 1'b0;
    wait_cycles(3);
    rxd_a = 1'b1;
    wait_cycles(30);
    @(negedge clk);
    check("a_false_start_count", 64'({valid_a, count_a}), 64'(0));
    wait_cycles(1);
    send_frame(0, 8'hA3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("a_a3_count", 64'(count_a), 64'(1));
    wait_cycles(1);
    drain(0, 2);

    // Odd parity: good frame, bad parity, break, clr
    send_frame(1, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("b_good_count", 64'(count_b), 64'(1));
    check("b_good_perr", 64'(perr_b), 64'(0));
    wait_cycles(1);
    drain(1, 2);
    send_frame(1, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("b_perr_set", 64'(perr_b), 64'(1));
    check("b_perr_count", 64'(count_b), 64'(0));
    check("b_perr_ferr", 64'(ferr_b), 64'(0));
    wait_cycles(1);
    pulse_clr(1);
    @(negedge clk);
    check("b_perr_cleared", 64'(perr_b), 64'(0));
    wait_cycles(1);
    send_frame(1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_cycles(100);
    @(negedge clk);
    check("b_ferr_set", 64'(ferr_b), 64'(1));
    check("b_ferr_precedence", 64'(perr_b), 64'(0));
    check("b_break_count", 64'({valid_b, count_b}), 64'(0));
    wait_cycles(1);
    rxd_b = 1'b1;
    wait_cycles(20);
    pulse_clr(1);
    @(negedge clk);
    check("b_flags_cleared", 64'({ferr_b, perr_b}), 64'(0));
    wait_cycles(1);
    send_frame(1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("b_after_break_count", 64'(count_b), 64'(1));
    wait_cycles(1);
    drain(1, 2);

    // Overflow: 17 bytes into 16 slots
    for (int i = 0; i < 17; i++) send_frame(0, 8'(i), 1'b0, 1'b1, (i < 16), 1'b0, 1'b0);
    @(negedge clk);
    check("a_full_count", 64'(count_a), 64'(16));
    check("a_overflow_set", 64'(ovf_a), 64'(1));
    wait_cycles(1);
    drain(0, 20);
    @(negedge clk);
    check("a_drained_count", 64'({valid_a, count_a}), 64'(0));
    check("a_queue_after_drain", 64'(q_a.size()), 64'(0));
    wait_cycles(1);
    pulse_clr(0);
    @(negedge clk);
    check("a_overflow_cleared", 64'(ovf_a), 64'(0));
    wait_cycles(1);

    // Push into a full FIFO in the same cycle as a pop
    for (int i = 0; i < 16; i++) send_frame(0, 8'(8'h20 + i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'h30, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("a_full_pushpop_count", 64'(count_a), 64'(16));
    check("a_full_pushpop_ovf", 64'(ovf_a), 64'(0));
    wait_cycles(1);
    drain(0, 20);
    @(negedge clk);
    check("a_queue_after_drain2", 64'(q_a.size()), 64'(0));
    wait_cycles(1);

    // Reset during data bit 4, with a byte parked in the FIFO
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("a_parked_data", 64'(data_a), 64'(8'h5A));
    wait_cycles(1);
    fork
      send_frame(0, 8'h96, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      begin
        repeat (88) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("a_midrst_valid_count", 64'({valid_a, count_a}), 64'(0));
        check("a_midrst_data", 64'(data_a), 64'(0));
        check("a_midrst_flags", 64'({ferr_a, perr_a, ovf_a, idle_a}), 64'(0));
        check("a_midrst_cycles", cycles_a, 64'(0));
      end
    join
    @(negedge clk);
    reset = 1'b0;
    wait_cycles(1);
    send_frame(0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("a_c3_count", 64'(count_a), 64'(1));
    check("a_c3_data", 64'(data_a), 64'(8'hC3));
    wait_cycles(1);
    drain(0, 2);

    @(negedge clk);
    check("a_queue_final", 64'(q_a.size()), 64'(0));
    check("b_queue_final", 64'(q_b.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
